vote_tally_fsm: RTL and testbench

Sequential, parametrised successor to the team's combinational four-candidate election comparator. Accepts individual votes over a valid/ready handshake and keeps per-candidate counters. On close it scans the counters to elect a winner. A tie at the maximum opens a jury round whose votes are restricted to the tied candidates. Sits between the ballot input logic and the result display.

---
 rtl/vote_tally_fsm.sv | 225 ++++++++++++++++++++++
 tb/tb_vote_tally_fsm.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/vote_tally_fsm.sv
// Sequential vote tally: counts ballots per candidate and scans for a winner.
// A tie at the maximum is resolved by a jury round restricted to the tied set.
module vote_tally_fsm #(
    parameter int unsigned NUM_CAND = 4,
    parameter int unsigned CAND_W   = 2,
    parameter int unsigned CNT_W    = 6,
    parameter int unsigned NUM_JURY = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              vote_valid,
    input  logic [CAND_W-1:0] vote_id,
    output logic              vote_ready,
    input  logic              close,
    input  logic              jury_valid,
    input  logic [CAND_W-1:0] jury_id,
    output logic              jury_ready,
    output logic [CAND_W-1:0] winner,
    output logic [CNT_W-1:0]  winner_votes,
    output logic              result_valid,
    output logic              tie_break_used,
    output logic              unresolved,
    output logic              overflow,
    output logic              busy
);

    localparam int unsigned JW = 4;
    localparam logic [CAND_W-1:0] LAST = CAND_W'(NUM_CAND - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_OPEN, S_SCAN, S_JURY, S_JSCAN, S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q [NUM_CAND];
    logic [CNT_W-1:0]    cnt_d [NUM_CAND];
    logic [JW-1:0]       jcnt_q [NUM_CAND];
    logic [JW-1:0]       jcnt_d [NUM_CAND];
    logic [CAND_W-1:0]   idx_q, idx_d;
    logic [CAND_W-1:0]   win_q, win_d;
    logic [CNT_W-1:0]    max_q, max_d;
    logic [NUM_CAND-1:0] mask_q, mask_d;
    logic [JW-1:0]       jmax_q, jmax_d;
    logic                jfound_q, jfound_d;
    logic                jtie_q, jtie_d;
    logic [JW-1:0]       jn_q, jn_d;
    logic [CAND_W-1:0]   winner_q, winner_d;
    logic [CNT_W-1:0]    winner_votes_q, winner_votes_d;
    logic                result_valid_q, result_valid_d;
    logic                tie_break_used_q, tie_break_used_d;
    logic                unresolved_q, unresolved_d;
    logic                overflow_q, overflow_d;
    logic                seen, multi;

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        jcnt_d           = jcnt_q;
        idx_d            = idx_q;
        win_d            = win_q;
        max_d            = max_q;
        mask_d           = mask_q;
        jmax_d           = jmax_q;
        jfound_d         = jfound_q;
        jtie_d           = jtie_q;
        jn_d             = jn_q;
        winner_d         = winner_q;
        winner_votes_d   = winner_votes_q;
        result_valid_d   = result_valid_q;
        tie_break_used_d = tie_break_used_q;
        unresolved_d     = unresolved_q;
        overflow_d       = overflow_q;
        seen             = 1'b0;
        multi            = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_OPEN;
                    for (int unsigned i = 0; i < NUM_CAND; i++) begin
                        cnt_d[i]  = '0;
                        jcnt_d[i] = '0;
                    end
                    winner_d         = '0;
                    winner_votes_d   = '0;
                    result_valid_d   = 1'b0;
                    tie_break_used_d = 1'b0;
                    unresolved_d     = 1'b0;
                    overflow_d       = 1'b0;
                end
            end
            S_OPEN: begin
                if (vote_valid && (32'(vote_id) < NUM_CAND)) begin
                    if (cnt_q[vote_id] == '1) overflow_d = 1'b1;
                    else cnt_d[vote_id] = cnt_q[vote_id] + CNT_W'(1);
                end
                if (close) begin
                    state_d = S_SCAN;
                    idx_d   = '0;
                end
            end
            S_SCAN: begin
                // Index 0 seeds the running max, so an all-zero tally ties every candidate.
                if (idx_q == '0 || cnt_q[idx_q] > max_q) begin
                    max_d         = cnt_q[idx_q];
                    mask_d        = '0;
                    mask_d[idx_q] = 1'b1;
                    win_d         = idx_q;
                end else if (cnt_q[idx_q] == max_q) begin
                    mask_d[idx_q] = 1'b1;
                end
                idx_d = idx_q + CAND_W'(1);
                if (idx_q == LAST) begin
                    for (int unsigned i = 0; i < NUM_CAND; i++) begin
                        if (mask_d[i]) begin
                            if (seen) multi = 1'b1;
                            seen = 1'b1;
                        end
                    end
                    if (multi) begin
                        state_d = S_JURY;
                        jn_d    = '0;
                        for (int unsigned i = 0; i < NUM_CAND; i++) jcnt_d[i] = '0;
                    end else begin
                        state_d          = S_DONE;
                        winner_d         = win_d;
                        winner_votes_d   = max_d;
                        result_valid_d   = 1'b1;
                        tie_break_used_d = 1'b0;
                        unresolved_d     = 1'b0;
                    end
                end
            end
            S_JURY: begin
                if (jury_valid) begin
                    jn_d = jn_q + JW'(1);
                    if ((32'(jury_id) < NUM_CAND) && mask_q[jury_id])
                        jcnt_d[jury_id] = jcnt_q[jury_id] + JW'(1);
                    if (jn_q == JW'(NUM_JURY - 1)) begin
                        state_d  = S_JSCAN;
                        idx_d    = '0;
                        jfound_d = 1'b0;
                        jtie_d   = 1'b0;
                    end
                end
            end
            S_JSCAN: begin
                if (mask_q[idx_q]) begin
                    if (!jfound_q || jcnt_q[idx_q] > jmax_q) begin
                        jmax_d   = jcnt_q[idx_q];
                        win_d    = idx_q;
                        jfound_d = 1'b1;
                        jtie_d   = 1'b0;
                    end else if (jcnt_q[idx_q] == jmax_q) begin
                        jtie_d = 1'b1;
                    end
                end
                idx_d = idx_q + CAND_W'(1);
                if (idx_q == LAST) begin
                    state_d          = S_DONE;
                    winner_d         = win_d;
                    winner_votes_d   = cnt_q[win_d];
                    result_valid_d   = 1'b1;
                    tie_break_used_d = 1'b1;
                    unresolved_d     = jtie_d;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            for (int unsigned i = 0; i < NUM_CAND; i++) begin
                cnt_q[i]  <= '0;
                jcnt_q[i] <= '0;
            end
            idx_q            <= '0;
            win_q            <= '0;
            max_q            <= '0;
            mask_q           <= '0;
            jmax_q           <= '0;
            jfound_q         <= 1'b0;
            jtie_q           <= 1'b0;
            jn_q             <= '0;
            winner_q         <= '0;
            winner_votes_q   <= '0;
            result_valid_q   <= 1'b0;
            tie_break_used_q <= 1'b0;
            unresolved_q     <= 1'b0;
            overflow_q       <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            jcnt_q           <= jcnt_d;
            idx_q            <= idx_d;
            win_q            <= win_d;
            max_q            <= max_d;
            mask_q           <= mask_d;
            jmax_q           <= jmax_d;
            jfound_q         <= jfound_d;
            jtie_q           <= jtie_d;
            jn_q             <= jn_d;
            winner_q         <= winner_d;
            winner_votes_q   <= winner_votes_d;
            result_valid_q   <= result_valid_d;
            tie_break_used_q <= tie_break_used_d;
            unresolved_q     <= unresolved_d;
            overflow_q       <= overflow_d;
        end
    end

    assign vote_ready     = (state_q == S_OPEN);
    assign jury_ready     = (state_q == S_JURY);
    assign busy           = (state_q != S_IDLE) && (state_q != S_DONE);
    assign winner         = winner_q;
    assign winner_votes   = winner_votes_q;
    assign result_valid   = result_valid_q;
    assign tie_break_used = tie_break_used_q;
    assign unresolved     = unresolved_q;
    assign overflow       = overflow_q;

endmodule

// File: tb/tb_vote_tally_fsm.sv
// Directed bench for vote_tally_fsm: four-candidate instance plus a
// three-candidate instance for out-of-range vote dropping.
module tb_vote_tally_fsm;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0, vote_valid = 1'b0, close = 1'b0, jury_valid = 1'b0;
    logic [1:0] vote_id = '0, jury_id = '0;
    logic       vote_ready, jury_ready, result_valid, tie_break_used, unresolved, overflow, busy;
    logic [1:0] winner;
    logic [5:0] winner_votes;

    logic       start3 = 1'b0, vote_valid3 = 1'b0, close3 = 1'b0;
    logic [1:0] vote_id3 = '0;
    logic       vote_ready3, jury_ready3, result_valid3, tie3, unres3, ovf3, busy3;
    logic [1:0] winner3;
    logic [5:0] winner_votes3;

    int checks = 0;
    int failures = 0;
    int lat;

    always #5 clk = ~clk;

    vote_tally_fsm #(.NUM_CAND(4), .CAND_W(2), .CNT_W(6), .NUM_JURY(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .vote_valid(vote_valid), .vote_id(vote_id),
        .vote_ready(vote_ready), .close(close), .jury_valid(jury_valid), .jury_id(jury_id),
        .jury_ready(jury_ready), .winner(winner), .winner_votes(winner_votes),
        .result_valid(result_valid), .tie_break_used(tie_break_used), .unresolved(unresolved),
        .overflow(overflow), .busy(busy)
    );

    vote_tally_fsm #(.NUM_CAND(3), .CAND_W(2), .CNT_W(6), .NUM_JURY(4)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .vote_valid(vote_valid3), .vote_id(vote_id3),
        .vote_ready(vote_ready3), .close(close3), .jury_valid(1'b0), .jury_id(2'b00),
        .jury_ready(jury_ready3), .winner(winner3), .winner_votes(winner_votes3),
        .result_valid(result_valid3), .tie_break_used(tie3), .unresolved(unres3),
        .overflow(ovf3), .busy(busy3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic cast(input logic [1:0] id, input int n);
        vote_valid = 1'b1;
        vote_id    = id;
        repeat (n) tick();
        vote_valid = 1'b0;
    endtask

    task automatic do_close();
        close = 1'b1; tick(); close = 1'b0;
    endtask

    // sel: 0 result_valid, 1 jury_ready, 2 result_valid of the 3-candidate instance
    task automatic wait_flag(input int sel, output int n);
        n = 0;
        while (!((sel == 0 && result_valid) || (sel == 1 && jury_ready) ||
                 (sel == 2 && result_valid3)) && n < 50) begin
            tick();
            n++;
        end
    endtask

    task automatic jury(input logic [1:0] a, input logic [1:0] b,
                        input logic [1:0] c, input logic [1:0] d);
        logic [1:0] v [4];
        v[0] = a; v[1] = b; v[2] = c; v[3] = d;
        jury_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            jury_id = v[i];
            tick();
        end
        jury_valid = 1'b0;
    endtask

    task automatic check_result(input string tag, input logic [1:0] w, input logic [5:0] wv,
                                input logic tb, input logic un);
        check({tag, ".valid"}, 32'(result_valid), 1);
        check({tag, ".winner"}, 32'(winner), 32'(w));
        check({tag, ".votes"}, 32'(winner_votes), 32'(wv));
        check({tag, ".tiebreak"}, 32'(tie_break_used), 32'(tb));
        check({tag, ".unresolved"}, 32'(unresolved), 32'(un));
    endtask

    task automatic tie_setup();
        do_start();
        cast(2'd0, 10); cast(2'd1, 20); cast(2'd2, 20); cast(2'd3, 5);
        do_close();
        wait_flag(1, lat);
        check("tie.jury_lat", 32'(lat), 4);
        check("tie.jury_ready", 32'(jury_ready), 1);
        check("tie.vote_ready", 32'(vote_ready), 0);
        check("tie.result_valid", 32'(result_valid), 0);
    endtask

    initial begin
        #12;
        check("rst.busy", 32'(busy), 0);
        check("rst.result_valid", 32'(result_valid), 0);
        check("rst.vote_ready", 32'(vote_ready), 0);
        check("rst.winner", 32'(winner), 0);
        check("rst.overflow", 32'(overflow), 0);
        rst_n = 1'b1;
        tick();

        // 1: clear winner D
        do_start();
        check("t1.vote_ready", 32'(vote_ready), 1);
        check("t1.busy", 32'(busy), 1);
        cast(2'd0, 17); cast(2'd1, 15); cast(2'd2, 15); cast(2'd3, 53);
        do_close();
        wait_flag(0, lat);
        check("t1.lat", 32'(lat), 4);
        check_result("t1", 2'd3, 6'd53, 1'b0, 1'b0);
        check("t1.overflow", 32'(overflow), 0);
        check("t1.busy_done", 32'(busy), 0);

        // 2: tie 1/2 resolved by jury, vote for 3 abstains
        tie_setup();
        jury(2'd1, 2'd1, 2'd2, 2'd3);
        wait_flag(0, lat);
        check("t2.lat", 32'(lat), 4);
        check_result("t2", 2'd1, 6'd20, 1'b1, 1'b0);

        // 3: jury also ties
        tie_setup();
        jury(2'd1, 2'd2, 2'd0, 2'd0);
        wait_flag(0, lat);
        check_result("t3", 2'd1, 6'd20, 1'b1, 1'b1);

        // 4: saturation
        do_start();
        check("t4.overflow_cleared", 32'(overflow), 0);
        cast(2'd2, 70);
        do_close();
        wait_flag(0, lat);
        check_result("t4", 2'd2, 6'd63, 1'b0, 1'b0);
        check("t4.overflow", 32'(overflow), 1);

        // 5: empty ballot, four-way tie
        do_start();
        do_close();
        wait_flag(1, lat);
        check("t5.jury_lat", 32'(lat), 4);
        jury(2'd3, 2'd3, 2'd3, 2'd0);
        wait_flag(0, lat);
        check_result("t5", 2'd3, 6'd0, 1'b1, 1'b0);
        check("t5.overflow", 32'(overflow), 0);

        // 6a: reset during SCAN
        do_start();
        cast(2'd1, 66);
        do_close();
        tick();
        check("t6.scan_busy", 32'(busy), 1);
        check("t6.scan_ovf", 32'(overflow), 1);
        #2 rst_n = 1'b0;
        #1;
        check("t6.rst_scan_busy", 32'(busy), 0);
        check("t6.rst_scan_ovf", 32'(overflow), 0);
        #3 rst_n = 1'b1;
        tick();

        // 6b: reset mid-JURY
        do_start();
        cast(2'd0, 5); cast(2'd1, 5);
        do_close();
        wait_flag(1, lat);
        check("t6.jury_ready", 32'(jury_ready), 1);
        jury_valid = 1'b1; jury_id = 2'd0; tick(); jury_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("t6.rst_jury_ready", 32'(jury_ready), 0);
        check("t6.rst_jury_busy", 32'(busy), 0);
        check("t6.rst_jury_result", 32'(result_valid), 0);
        #3 rst_n = 1'b1;
        tick();

        // 6c: fresh run after reset
        do_start();
        cast(2'd2, 3); cast(2'd1, 1);
        do_close();
        wait_flag(0, lat);
        check_result("t6c", 2'd2, 6'd3, 1'b0, 1'b0);

        // 6d: three candidates, votes for id 3 dropped
        start3 = 1'b1; tick(); start3 = 1'b0;
        vote_valid3 = 1'b1;
        vote_id3 = 2'd3; repeat (5) tick();
        vote_id3 = 2'd0; repeat (2) tick();
        vote_id3 = 2'd1; tick();
        vote_id3 = 2'd2; tick();
        vote_valid3 = 1'b0;
        close3 = 1'b1; tick(); close3 = 1'b0;
        wait_flag(2, lat);
        check("t6d.lat", 32'(lat), 3);
        check("t6d.valid", 32'(result_valid3), 1);
        check("t6d.winner", 32'(winner3), 0);
        check("t6d.votes", 32'(winner_votes3), 2);
        check("t6d.tiebreak", 32'(tie3), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
